// File: rtl/mealy_seq_ctrl_if.sv
// Host-side bus of the Mealy detector run controller: run request,
// captured stimulus and run results. The host drives through the master
// modport, and the controller uses the slave modport.
interface mealy_seq_ctrl_if #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 8
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] run_len;
  logic             busy;
  logic             done;
  logic             err;
  logic             x_out;
  logic [1:0]       state_q;
  logic             y;
  logic [LEN_W-1:0] hit_cnt;

  modport master (
    output start, pattern, run_len,
    input  busy, done, err, x_out, state_q, y, hit_cnt
  );

  modport slave (
    input  start, pattern, run_len,
    output busy, done, err, x_out, state_q, y, hit_cnt
  );
endinterface

// File: rtl/mealy_seq_ctrl.sv
// Run controller for the 2-bit T-flip-flop Mealy detector. It captures a
// stimulus pattern and a run length, shifts the pattern out LSB first for
// run_len cycles while advancing the toggle counter, and counts the cycles
// where the Mealy output y = x & q1 & ~q0 fires. Every output except y
// comes straight from a flop.
module mealy_seq_ctrl #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 8
) (
  input  logic CLK,
  input  logic RST,
  mealy_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t             fsm_q,     fsm_d;
  logic [PAT_W-1:0] pat_reg_q, pat_reg_d;
  logic [LEN_W-1:0] remain_q,  remain_d;
  logic [1:0]       state_q,   state_d;
  logic [LEN_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;
  logic             x_out_q,   x_out_d;
  logic             y;

  // The Mealy output is derived combinationally from the registered stimulus bit and counter.
  assign y = x_out_q & state_q[1] & ~state_q[0];

  // Next-state logic. Each output is computed from the next FSM state so it
  // can be registered and still line up with the state it belongs to.
  always_comb begin
    fsm_d     = fsm_q;
    pat_reg_d = pat_reg_q;
    remain_d  = remain_q;
    state_d   = state_q;
    hit_cnt_d = hit_cnt_q;
    err_d     = bus.start && (fsm_q != IDLE);

    case (fsm_q)
      IDLE: begin
        if (bus.start) begin
          pat_reg_d = bus.pattern;
          remain_d  = bus.run_len;
          state_d   = 2'b00;
          hit_cnt_d = '0;
          fsm_d     = (bus.run_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        state_d[0] = state_q[0] ^ x_out_q;
        state_d[1] = state_q[1] ^ (x_out_q & state_q[0]);
        hit_cnt_d  = hit_cnt_q + {{(LEN_W-1){1'b0}}, y};
        pat_reg_d  = {pat_reg_q[0], pat_reg_q[PAT_W-1:1]};
        remain_d   = remain_q - LEN_W'(1);
        if (remain_q == LEN_W'(1)) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

    busy_d  = (fsm_d != IDLE);
    done_d  = (fsm_d == DONE);
    x_out_d = (fsm_d == RUN) ? pat_reg_d[0] : 1'b0;
  end

  // State and registered outputs. Reset clears everything, including a run in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_q     <= IDLE;
      pat_reg_q <= '0;
      remain_q  <= '0;
      state_q   <= 2'b00;
      hit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      x_out_q   <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      pat_reg_q <= pat_reg_d;
      remain_q  <= remain_d;
      state_q   <= state_d;
      hit_cnt_q <= hit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      x_out_q   <= x_out_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.x_out   = x_out_q;
  assign bus.state_q = state_q;
  assign bus.y       = y;
  assign bus.hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// Directed testbench for mealy_seq_ctrl. Inputs are driven and outputs are
// sampled on the falling clock edge, well away from the active rising edge.
module tb_mealy_seq_ctrl;

  localparam int PAT_W = 16;
  localparam int LEN_W = 8;

  logic CLK;
  logic RST;
  int   assertCount;
  int   failCount;

  mealy_seq_ctrl_if #(.PAT_W(PAT_W), .LEN_W(LEN_W)) bus ();

  mealy_seq_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks that every output sits at its cleared value.
  task automatic checkCleared(input string tag);
    checkOutput({tag, " busy"},    32'(bus.busy),    32'd0);
    checkOutput({tag, " done"},    32'(bus.done),    32'd0);
    checkOutput({tag, " err"},     32'(bus.err),     32'd0);
    checkOutput({tag, " x_out"},   32'(bus.x_out),   32'd0);
    checkOutput({tag, " state_q"}, 32'(bus.state_q), 32'd0);
    checkOutput({tag, " y"},       32'(bus.y),       32'd0);
    checkOutput({tag, " hit_cnt"}, 32'(bus.hit_cnt), 32'd0);
  endtask

  // Runs one complete transaction and checks it cycle by cycle. Cycle c is
  // the c-th cycle after the edge that accepts start. colA/colB name the
  // cycles during which start is pulsed again (-1 for none); err must
  // appear in the cycle that follows each such pulse.
  task automatic applyStimulus(input string tag, input logic [PAT_W-1:0] pat,
                               input int len, input int expHits, input int expState,
                               input int colA, input int colB);
    int yCount;
    yCount = 0;
    @(negedge CLK);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.run_len = LEN_W'(len);
    @(negedge CLK);
    bus.start   = 1'b0;
    bus.pattern = ~pat;
    bus.run_len = LEN_W'(len + 3);
    for (int c = 1; c <= len + 2; c++) begin
      if (c > 1) @(negedge CLK);
      if (c <= len) begin
        checkOutput({tag, " run x_out"}, 32'(bus.x_out), 32'(pat[(c-1) % PAT_W]));
        checkOutput({tag, " run busy"},  32'(bus.busy),  32'd1);
        checkOutput({tag, " run done"},  32'(bus.done),  32'd0);
        if (bus.y === 1'b1) yCount++;
      end else if (c == len + 1) begin
        checkOutput({tag, " done pulse"}, 32'(bus.done),  32'd1);
        checkOutput({tag, " done busy"},  32'(bus.busy),  32'd1);
        checkOutput({tag, " done x_out"}, 32'(bus.x_out), 32'd0);
      end else begin
        checkOutput({tag, " idle done"},    32'(bus.done),    32'd0);
        checkOutput({tag, " idle busy"},    32'(bus.busy),    32'd0);
        checkOutput({tag, " final hit_cnt"}, 32'(bus.hit_cnt), 32'(expHits));
        checkOutput({tag, " final state_q"}, 32'(bus.state_q), 32'(expState));
      end
      checkOutput({tag, " err"}, 32'(bus.err), 32'((c - 1 == colA) || (c - 1 == colB)));
      bus.start = ((c == colA) || (c == colB)) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    checkOutput({tag, " y count"}, 32'(yCount), 32'(expHits));
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    RST         = 1'b1;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.run_len = '0;

    repeat (2) @(negedge CLK);
    checkCleared("reset");
    RST = 1'b0;

    // Reset mid-run: start an all-ones run and hit reset during RUN cycle 3.
    @(negedge CLK);
    bus.start   = 1'b1;
    bus.pattern = 16'hFFFF;
    bus.run_len = 8'd8;
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("midrun y before reset", 32'(bus.y), 32'd1);
    RST = 1'b1;
    #1;
    checkCleared("midrun reset");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkCleared("after reset");

    applyStimulus("allones", 16'hFFFF, 8, 2, 0, -1, -1);
    applyStimulus("sparse5", 16'h0005, 4, 0, 2, -1, -1);
    applyStimulus("sparse7", 16'h0007, 3, 1, 3, -1, -1);
    applyStimulus("wrap",    16'hFFFF, 20, 5, 0, -1, -1);
    applyStimulus("zero",    16'hFFFF, 0, 0, 0, -1, -1);
    applyStimulus("collide", 16'hFFFF, 8, 2, 0, 4, 9);
    applyStimulus("mixed",   16'h00B6, 8, 1, 1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mealy_seq_ctrl.md
# mealy_seq_ctrl

Run controller for the team's 2-bit T-flip-flop Mealy detector datapath. It loads a stimulus pattern and run length, drives the serial input `x` for exactly `run_len` cycles, and advances an internal 2-bit toggle counter. It also evaluates the Mealy output `y = x & q[1] & ~q[0]` and counts detections. A start/busy/done handshake lets a host sequence repeated runs without direct clock-level control of the detector.

## Interface
Parameters:
- PAT_W, 16, stimulus pattern width; the pattern is applied LSB first and rotates when `run_len > PAT_W`.
- LEN_W, 8, width of `run_len` and `hit_cnt`.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  run request, sampled only in IDLE.
- pattern  in  PAT_W  stimulus bits, captured with `start`.
- run_len  in  LEN_W  number of RUN cycles, captured with `start`; 0 is legal.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  one-cycle pulse when `start` is seen while busy.
- x_out  out  1  current stimulus bit; 0 outside RUN.
- state_q  out  2  detector counter state.
- y  out  1  combinational Mealy output, `x_out & state_q[1] & ~state_q[0]`.
- hit_cnt  out  LEN_W  number of `y` cycles in the current or last run; held after the run.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - On `start=1`, capture `pattern` into `pat_reg` and `run_len` into `remain`.
  - Clear `state_q` and `hit_cnt`.
  - Go to RUN, or go directly to DONE if `run_len == 0`.
- **RUN, each cycle:**
  - `x_out = pat_reg[0]`.
  - At the edge, `state_q[0]` toggles if `x_out`, and `state_q[1]` toggles if `x_out & state_q[0]`. This is the T-ff rule with T0 = x and T1 = x & q0, so the counter counts 0→1→2→3→0 on each x=1 and holds on x=0.
  - `hit_cnt += y`.
  - `pat_reg` rotates right by 1, so bit 0 wraps to bit PAT_W-1.
  - `remain` decrements.
  - When `remain == 1` at the edge, go to DONE.
- **DONE:**
  - `done=1` for exactly one cycle, then go to IDLE.
  - `state_q` and `hit_cnt` hold until the next accepted `start`.
- **No saturation needed:** `hit_cnt` cannot overflow, since at most one hit occurs per 4 RUN cycles.
- **Start while busy:**
  - `start=1` in RUN or DONE is ignored and pulses `err` on the following cycle.
  - Captured values are unchanged.
- **Input changes:** `pattern` and `run_len` changes after capture have no effect.
- **Reset:**
  - RST asserted at any time forces IDLE immediately, mid-run included.
  - All outputs go to 0: `busy`, `done`, `err`, `x_out`, `state_q`, `y`, `hit_cnt`.
  - Internal `pat_reg` and `remain` are cleared.

## Timing
- `start` sampled high at edge k:
  - `busy=1` from edge k.
  - RUN occupies the cycles after edges k … k+N-1, where N = `run_len`.
  - `done=1` in the cycle after edge k+N.
  - `busy` falls at edge k+N+1.
- **run_len = 0:** DONE during the cycle after edge k, so `done` follows `start` by one cycle.
- **Back-to-back runs:** earliest next accepted `start` is the IDLE cycle after DONE, giving 2 cycles of overhead per run.
- **y is combinational:** it reflects the current `x_out` and `state_q` within the same cycle and is valid only while in RUN.
- `hit_cnt` and `state_q` update at the same edge that consumes each RUN cycle.

## Test plan
- **Reset:** assert RST mid-run, with `pattern=16'hFFFF`, `run_len=8`, at RUN cycle 3 → all outputs 0 the same cycle; after release, IDLE; a new `start` runs normally.
- **All-ones pattern:** `pattern=16'hFFFF`, `run_len=8` → `y` high in RUN cycles 3 and 7, `hit_cnt=2`, final `state_q=0`, `done` exactly 9 cycles after the `start` edge.
- **Sparse patterns:**
  - `pattern=16'h0005`, `run_len=4` → x = 1,0,1,0; `hit_cnt=0`; final `state_q=2`.
  - Then `pattern=16'h0007`, `run_len=3` → `hit_cnt=1`, final `state_q=3`.
- **Wrap-around:** `pattern=16'hFFFF`, `run_len=20` → pattern rotates; `hit_cnt=5` (cycles 3, 7, 11, 15, 19); final `state_q=0`.
- **Zero length:** `run_len=0` → `done` one cycle after `start`, `x_out` never high, `hit_cnt=0`.
- **Busy collision:** `start` pulsed during RUN and again during DONE → `err` pulses once for each; run results match an undisturbed run.
